vedic_mult_seq_ctrl: RTL

- Sequencer that computes a full WIDTH x WIDTH unsigned product by time-sharing one external HALF x HALF Vedic multiplier core over four passes.
- Partial products are accumulated in a 2*WIDTH-bit shift-add accumulator.
- Sits between a valid/ready request interface and the shared half-width multiplier.
- Trades area for latency: the full 64-bit array is replaced by one 32x32 core plus this controller.

---
 rtl/vedic_mult_seq_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/vedic_mult_seq_ctrl.sv
// Full WIDTH x WIDTH unsigned multiply built from four passes through one shared
// HALF x HALF multiplier core, accumulating shifted partial products.
module vedic_mult_seq_ctrl #(
    parameter int WIDTH   = 64,
    parameter int MUL_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p,
    output logic                 busy,
    output logic [WIDTH/2-1:0]   mul_a,
    output logic [WIDTH/2-1:0]   mul_b,
    input  logic [WIDTH-1:0]     mul_p
);

    localparam int HALF = WIDTH / 2;
    localparam int CW   = (MUL_LAT > 0) ? $clog2(MUL_LAT + 1) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(MUL_LAT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   out_p_q, out_p_d;
    logic [1:0]           pass_q, pass_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    logic [2*WIDTH-1:0]   pp_ext;
    logic [2*WIDTH-1:0]   pp_shift;
    logic [2*WIDTH-1:0]   acc_sum;

    // Pass weight: 0 -> aL*bL, 1/2 -> cross terms at HALF, 3 -> aH*bH at WIDTH.
    always_comb begin
        pp_ext = {{WIDTH{1'b0}}, mul_p};
        case (pass_q)
            2'd0:    pp_shift = pp_ext;
            2'd3:    pp_shift = pp_ext << WIDTH;
            default: pp_shift = pp_ext << HALF;
        endcase
        acc_sum = acc_q + pp_shift;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        out_p_d = out_p_q;
        pass_d  = pass_q;
        cnt_d   = cnt_q;
        mul_a   = '0;
        mul_b   = '0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    acc_d   = '0;
                    pass_d  = 2'd0;
                    cnt_d   = CNT_INIT;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Operands depend only on pass_q, so they hold steady for the
                // whole latency window of the core.
                mul_a = pass_q[1] ? a_q[WIDTH-1:HALF] : a_q[HALF-1:0];
                mul_b = pass_q[0] ? b_q[WIDTH-1:HALF] : b_q[HALF-1:0];
                if (cnt_q == '0) begin
                    acc_d = acc_sum;
                    cnt_d = CNT_INIT;
                    if (pass_q == 2'd3) begin
                        out_p_d = acc_sum;
                        state_d = DONE;
                    end else begin
                        pass_d = pass_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            out_p_q <= '0;
            pass_q  <= 2'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            out_p_q <= out_p_d;
            pass_q  <= pass_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_p     = out_p_q;

endmodule
